adc_sample_ctrl: RTL and testbench

- Upstream of the system monitor. Converts the monitor's periodic one-cycle ADC request into a complete SPI read of an external 14-bit ADC.
- Sequence: mux-settle delay, then a chip-select framed SPI transfer, then a one-cycle ready pulse with the sampled value. These feed the monitor's battery averaging and AA/Li detection.
- Flags requests that arrive during a conversion with a sticky overrun bit.

---
 rtl/adc_sample_ctrl_if.sv | 27 ++
 rtl/adc_sample_ctrl.sv | 164 ++++++++++++++++
 tb/tb_adc_sample_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_ctrl_if.sv
// Bundles the signals between the ADC sample controller, the system monitor
// that requests conversions, and the external SPI ADC.
interface adc_sample_ctrl_if #(
  parameter int DATA_BITS = 14
);
  logic                 adc_req;
  logic                 overrun_clr;
  logic                 spi_miso;
  logic                 spi_cs_n;
  logic                 spi_sclk;
  logic                 adc_busy;
  logic                 adc_ready;
  logic [DATA_BITS-1:0] adc_value;
  logic                 adc_overrun;

  // Monitor/ADC side: raises requests, clears overrun, supplies MISO.
  modport master (
    output adc_req, overrun_clr, spi_miso,
    input  spi_cs_n, spi_sclk, adc_busy, adc_ready, adc_value, adc_overrun
  );

  // Controller side.
  modport slave (
    input  adc_req, overrun_clr, spi_miso,
    output spi_cs_n, spi_sclk, adc_busy, adc_ready, adc_value, adc_overrun
  );
endinterface

// File: rtl/adc_sample_ctrl.sv
// ADC sample controller: turns a request edge into mux settling, a
// chip-select framed mode-0 SPI read of an external ADC, and a one-cycle
// ready pulse carrying the last DATA_BITS bits of the frame.
module adc_sample_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_BITS     = 14,
  parameter int CS_GAP        = 2
) (
  input  logic              clk,
  input  logic              reset,
  adc_sample_ctrl_if.slave  ctrl_if
);

  localparam int GAP_CYCLES = CS_GAP * CLK_DIV;
  localparam int CNT_MAX_A  = (SETTLE_CYCLES > CLK_DIV) ? SETTLE_CYCLES : CLK_DIV;
  localparam int CNT_MAX    = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CS_SETUP,
    SHIFT,
    GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] value_q, value_d;
  logic                 csN_q, csN_d;
  logic                 sclk_q, sclk_d;
  logic                 ready_q, ready_d;
  logic                 overrun_q, overrun_d;
  logic                 reqPrev_q;
  logic                 reqEdge;

  assign reqEdge = ctrl_if.adc_req & ~reqPrev_q;

  // State and datapath registers; reset drops CS and SCLK immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      value_q   <= '0;
      csN_q     <= 1'b1;
      sclk_q    <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      reqPrev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      value_q   <= value_d;
      csN_q     <= csN_d;
      sclk_q    <= sclk_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      reqPrev_q <= ctrl_if.adc_req;
    end
  end

  // Sequencing: settle, CS setup, clocked shift, then enforced CS-high gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    value_d   = value_q;
    csN_d     = csN_q;
    sclk_d    = sclk_q;
    ready_d   = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (reqEdge) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CS_SETUP;
          csN_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CS_SETUP: begin
        if (cnt_q == PHASE_LAST) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          bitCnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != PHASE_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: the ADC has had a full low phase to present the bit.
            sclk_d  = 1'b1;
            shift_d = {shift_q[DATA_BITS-2:0], ctrl_if.spi_miso};
          end else if (bitCnt_q == BIT_LAST) begin
            sclk_d  = 1'b0;
            csN_d   = 1'b1;
            value_d = shift_q;
            ready_d = 1'b1;
            state_d = GAP;
          end else begin
            sclk_d   = 1'b0;
            bitCnt_d = bitCnt_q + BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        csN_d   = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    // A request arriving mid-conversion is dropped but remembered; set beats clear.
    if (reqEdge && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (ctrl_if.overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  assign ctrl_if.spi_cs_n    = csN_q;
  assign ctrl_if.spi_sclk    = sclk_q;
  assign ctrl_if.adc_busy    = (state_q != IDLE);
  assign ctrl_if.adc_ready   = ready_q;
  assign ctrl_if.adc_value   = value_q;
  assign ctrl_if.adc_overrun = overrun_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Self-checking bench for adc_sample_ctrl: a default-parameter instance and a
// fast instance (CLK_DIV=1, no settle, 14-bit frame), each fed by an ADC model.
module tb_adc_sample_ctrl;

  localparam int A_DIV = 4, A_SET = 16, A_FRAME = 16, A_DATA = 14, A_GAP = 2;
  localparam int B_DIV = 1, B_SET = 0,  B_FRAME = 14, B_DATA = 14, B_GAP = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  adc_sample_ctrl_if #(.DATA_BITS(A_DATA)) busA ();
  adc_sample_ctrl_if #(.DATA_BITS(B_DATA)) busB ();

  adc_sample_ctrl #(
    .CLK_DIV(A_DIV), .SETTLE_CYCLES(A_SET), .FRAME_BITS(A_FRAME),
    .DATA_BITS(A_DATA), .CS_GAP(A_GAP)
  ) dutA (
    .clk(clk), .reset(reset), .ctrl_if(busA)
  );

  adc_sample_ctrl #(
    .CLK_DIV(B_DIV), .SETTLE_CYCLES(B_SET), .FRAME_BITS(B_FRAME),
    .DATA_BITS(B_DATA), .CS_GAP(B_GAP)
  ) dutB (
    .clk(clk), .reset(reset), .ctrl_if(busB)
  );

  // ADC models: MSB presented when CS falls, next bit after each SCLK fall.
  logic [A_FRAME-1:0] frameA = '0;
  logic [B_FRAME-1:0] frameB = '0;
  int idxA = 0;
  int idxB = 0;

  always @(negedge busA.spi_cs_n) idxA = 0;
  always @(negedge busA.spi_sclk) idxA = idxA + 1;
  always @(negedge busB.spi_cs_n) idxB = 0;
  always @(negedge busB.spi_sclk) idxB = idxB + 1;

  assign busA.spi_miso = (idxA < A_FRAME) ? frameA[A_FRAME-1-idxA] : 1'b0;
  assign busB.spi_miso = (idxB < B_FRAME) ? frameB[B_FRAME-1-idxB] : 1'b0;

  int checks = 0;
  int passed = 0;

  int obsReadyCount, obsReadyAt, obsLastReadyAt, obsSclkRises, obsSclkBad, obsBusyEnd;
  logic [13:0] obsValue;
  logic obsOverrun;

  typedef struct {
    logic [15:0] frame;
    logic [13:0] expValue;
  } vector_t;

  vector_t vectors[5];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int readyLatency(input int div, input int settle, input int frameBits);
    return 1 + settle + div + 2 * div * frameBits;
  endfunction

  task automatic setReq(input int which, input logic v);
    if (which == 0) busA.adc_req = v;
    else busB.adc_req = v;
  endtask

  task automatic sample(input int which, output logic cs, output logic sclk,
                        output logic rdy, output logic busy,
                        output logic [13:0] val, output logic ovr);
    if (which == 0) begin
      cs = busA.spi_cs_n; sclk = busA.spi_sclk; rdy = busA.adc_ready;
      busy = busA.adc_busy; val = busA.adc_value; ovr = busA.adc_overrun;
    end else begin
      cs = busB.spi_cs_n; sclk = busB.spi_sclk; rdy = busB.adc_ready;
      busy = busB.adc_busy; val = busB.adc_value; ovr = busB.adc_overrun;
    end
  endtask

  // Raise a request before edge T0, optionally a second edge at T0+secondAt and
  // an overrun clear at T0+clrAt; observation k is taken after edge T0+k.
  task automatic applyStimulus(input int which, input int reqHold, input int secondAt,
                               input int clrAt, input int cycles);
    logic cs, sclk, rdy, busy, ovr, prevSclk;
    logic [13:0] val;
    obsReadyCount = 0; obsReadyAt = -1; obsLastReadyAt = -1; obsValue = '0;
    obsSclkRises = 0; obsSclkBad = 0; obsBusyEnd = -1; obsOverrun = 1'b0;
    prevSclk = 1'b0;
    @(negedge clk);
    setReq(which, 1'b1);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (k + 1 == reqHold) setReq(which, 1'b0);
      if (secondAt > 0 && k == secondAt - 1) setReq(which, 1'b1);
      if (secondAt > 0 && k == secondAt) setReq(which, 1'b0);
      if (clrAt > 0 && k == clrAt - 1) busA.overrun_clr = 1'b1;
      if (clrAt > 0 && k == clrAt) busA.overrun_clr = 1'b0;
      sample(which, cs, sclk, rdy, busy, val, ovr);
      if (rdy) begin
        obsReadyCount++;
        obsLastReadyAt = k;
        if (obsReadyAt < 0) begin
          obsReadyAt = k;
          obsValue = val;
        end
      end
      if (!cs && sclk && !prevSclk) obsSclkRises++;
      if (cs && sclk) obsSclkBad++;
      if (!busy && obsBusyEnd < 0 && k >= 1) obsBusyEnd = k;
      prevSclk = sclk;
      obsOverrun = ovr;
    end
    setReq(which, 1'b0);
  endtask

  task automatic checkConversion(input string tag, input int which, input logic [13:0] expValue,
                                 input int expCount, input int secondAt, input logic expOverrun);
    int div, settle, frameBits, gap, lat;
    div = (which == 0) ? A_DIV : B_DIV;
    settle = (which == 0) ? A_SET : B_SET;
    frameBits = (which == 0) ? A_FRAME : B_FRAME;
    gap = (which == 0) ? A_GAP : B_GAP;
    lat = readyLatency(div, settle, frameBits);
    checkOutput($sformatf("%s readyCount", tag), 32'(obsReadyCount), 32'(expCount));
    checkOutput($sformatf("%s readyAt", tag), 32'(obsReadyAt), 32'(lat));
    checkOutput($sformatf("%s value", tag), 32'(obsValue), 32'(expValue));
    checkOutput($sformatf("%s sclkRises", tag), 32'(obsSclkRises), 32'(frameBits * expCount));
    checkOutput($sformatf("%s sclkOutsideCs", tag), 32'(obsSclkBad), 32'd0);
    checkOutput($sformatf("%s busyEnd", tag), 32'(obsBusyEnd), 32'(lat + gap * div));
    checkOutput($sformatf("%s overrun", tag), 32'(obsOverrun), 32'(expOverrun));
    if (expCount == 2)
      checkOutput($sformatf("%s secondReadyAt", tag), 32'(obsLastReadyAt), 32'(secondAt + lat));
  endtask

  initial begin
    logic [15:0] rnd;
    int readyLeak;

    reset = 1'b1;
    busA.adc_req = 1'b0; busA.overrun_clr = 1'b0;
    busB.adc_req = 1'b0; busB.overrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of the default instance
    checkOutput("reset cs_n", 32'(busA.spi_cs_n), 32'd1);
    checkOutput("reset sclk", 32'(busA.spi_sclk), 32'd0);
    checkOutput("reset busy", 32'(busA.adc_busy), 32'd0);
    checkOutput("reset ready", 32'(busA.adc_ready), 32'd0);
    checkOutput("reset value", 32'(busA.adc_value), 32'd0);
    checkOutput("reset overrun", 32'(busA.adc_overrun), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed value vectors, including discarded non-zero pad bits
    vectors[0] = '{16'b0001_1001_1110_0010, 14'h19E2};
    vectors[1] = '{16'h0000, 14'h0000};
    vectors[2] = '{16'h2AAA, 14'h2AAA};
    vectors[3] = '{16'hD234, 14'h1234};
    vectors[4] = '{16'hFFFF, 14'h3FFF};
    for (int i = 0; i < 5; i++) begin
      frameA = vectors[i].frame;
      applyStimulus(0, 1, -1, -1, 170);
      checkConversion($sformatf("vec%0d", i), 0, vectors[i].expValue, 1, -1, 1'b0);
    end

    // Random frames against the last-DATA_BITS-bits rule
    for (int i = 0; i < 4; i++) begin
      rnd = 16'($urandom);
      frameA = rnd;
      applyStimulus(0, 1, -1, -1, 170);
      checkConversion($sformatf("rndA%0d", i), 0, 14'(rnd % (1 << A_DATA)), 1, -1, 1'b0);
    end

    // Held request converts once only
    frameA = 16'h1ABC;
    applyStimulus(0, 300, -1, -1, 330);
    checkConversion("held", 0, 14'h1ABC, 1, -1, 1'b0);

    // Fresh edge after the first conversion finished starts another
    frameA = 16'h0F0F;
    applyStimulus(0, 1, 200, -1, 400);
    checkConversion("second", 0, 14'h0F0F, 2, 200, 1'b0);

    // Edge during conversion: flagged, discarded, result still delivered
    frameA = 16'h3456;
    applyStimulus(0, 1, 50, -1, 200);
    checkConversion("overrun", 0, 14'h3456, 1, -1, 1'b1);

    // Clear coincident with an overrun edge: set wins
    frameA = 16'h0123;
    applyStimulus(0, 1, 40, 40, 200);
    checkConversion("setWins", 0, 14'h0123, 1, -1, 1'b1);

    // Clear on its own
    @(negedge clk); busA.overrun_clr = 1'b1;
    @(negedge clk); busA.overrun_clr = 1'b0;
    checkOutput("clear overrun", 32'(busA.adc_overrun), 32'd0);

    // Reset in the middle of the shift phase
    frameA = 16'h2222;
    @(negedge clk); busA.adc_req = 1'b1;
    for (int k = 0; k <= 80; k++) begin
      @(negedge clk);
      if (k == 0) busA.adc_req = 1'b0;
    end
    checkOutput("midShift cs_n before reset", 32'(busA.spi_cs_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midShift cs_n", 32'(busA.spi_cs_n), 32'd1);
    checkOutput("midShift sclk", 32'(busA.spi_sclk), 32'd0);
    checkOutput("midShift busy", 32'(busA.adc_busy), 32'd0);
    checkOutput("midShift value", 32'(busA.adc_value), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    readyLeak = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (busA.adc_ready) readyLeak++;
    end
    checkOutput("midShift no ready", 32'(readyLeak), 32'd0);
    frameA = 16'h1357;
    applyStimulus(0, 1, -1, -1, 170);
    checkConversion("afterReset", 0, 14'h1357, 1, -1, 1'b0);

    // Fast instance: all ones, then back-to-back just after busy drops
    frameB = 14'h3FFF;
    applyStimulus(1, 1, -1, -1, 50);
    checkConversion("fastOnes", 1, 14'h3FFF, 1, -1, 1'b0);
    frameB = 14'h2AAA;
    applyStimulus(1, 1, readyLatency(B_DIV, B_SET, B_FRAME) + B_GAP * B_DIV + 1, -1, 100);
    checkConversion("fastB2B", 1, 14'h2AAA, 2,
                    readyLatency(B_DIV, B_SET, B_FRAME) + B_GAP * B_DIV + 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rnd = 16'($urandom);
      frameB = 14'(rnd);
      applyStimulus(1, 1, -1, -1, 50);
      checkConversion($sformatf("rndB%0d", i), 1, 14'(rnd % (1 << B_DATA)), 1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
